pio_in_debounced: RTL and testbench
===================================

# pio_in_debounced

- Parametrised Avalon-MM input port for push-buttons and slide switches.
- Successor to the fixed 2-bit key port; adds:
  - configurable channel count and edge polarity;
  - per-channel debounce;
  - per-bit interrupt mask with an `irq` output;
  - per-bit write-1-to-clear edge capture.
- Sits between board-level `in_port` pins and the CPU data master, as a slave on the system interconnect.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `reset_n`).

Parameters:
- `WIDTH`, 4 — number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, 50000 — consecutive stable clocks required to accept a level change, ≥1.
- `EDGE_MODE`, 0 — edge that sets capture: 0 rising, 1 falling, 2 any.
- `IDLE_LEVEL`, 1 — reset level of the synchroniser and stable registers, replicated across all channels.

Ports:
- `clk` in 1 — system clock.
- `reset_n` in 1 — asynchronous active-low reset.
- `address` in 2 — register select.
- `chipselect` in 1 — slave select.
- `write_n` in 1 — active-low write strobe.
- `writedata` in 32 — write data.
- `in_port` in `WIDTH` — raw asynchronous inputs.
- `readdata` out 32 — registered read data; bits 31..`WIDTH` are always 0.
- `irq` out 1 — level interrupt.

## Operation
- Register map:
  - 0 DATA (RO): debounced level `stable`.
  - 1 RAW (RO): synchronised input `sync2`.
  - 2 IRQMASK (RW): `irq_mask`, reset 0.
  - 3 EDGECAP (R, write-1-to-clear per bit): `edge_capture`, reset 0.
- Writes to 0 and 1 are ignored. A write is `chipselect && !write_n`.
- Input path per channel: `in_port` → `sync1` → `sync2` (2-FF synchroniser) → debouncer → `stable`.
- Debouncer, one counter of width `$clog2(DEBOUNCE_CYCLES+1)` per channel:
  - `sync2 == stable`: counter cleared.
  - `sync2 != stable` and counter < `DEBOUNCE_CYCLES-1`: counter increments.
  - `sync2 != stable` and counter == `DEBOUNCE_CYCLES-1`: `stable` <= `sync2` and counter cleared.
  - A glitch shorter than `DEBOUNCE_CYCLES` clocks never reaches `stable`; its count restarts from 0.
- Edge detect uses `stable_d`, which is `stable` delayed one clock:
  - rise = `stable & ~stable_d`;
  - fall = `~stable & stable_d`;
  - `EDGE_MODE` selects rise, fall or either.
- Edge capture per bit:
  - sets on a detected edge;
  - clears on an EDGECAP write with `writedata[i]`=1;
  - if a set and a clear hit the same bit in the same clock, the set wins (no lost edge).
- `irq` = OR over `edge_capture & irq_mask`. It is a combinational function of registers only.
- `readdata` is registered every clock from the mux on `address`, independent of `chipselect`. Address 0 with no read still updates it.
- Reset values:
  - `sync1`, `sync2`, `stable`, `stable_d` = {`WIDTH`{`IDLE_LEVEL`}};
  - counters = 0;
  - `edge_capture` = 0, `irq_mask` = 0, `readdata` = 0;
  - so `irq` = 0.
- Reset mid-count discards the partial count. No spurious edge is produced after reset while inputs sit at `IDLE_LEVEL`.

## Timing
- Input change latency. For an `in_port` change sampled at edge n, held steady:
  - `sync2` changes at n+2;
  - `stable` changes at n+2+`DEBOUNCE_CYCLES`;
  - `edge_capture` sets at n+3+`DEBOUNCE_CYCLES`;
  - `irq` rises in the same cycle if masked in.
- Read latency: `readdata` is valid one clock after `address` is presented (Avalon fixed read latency 1).
- Write latency: a write takes effect at the clock edge that samples it. `irq` falls in the cycle after an EDGECAP clear (or mask clear) is sampled.

## Configuration
- Macro: `PIO_IN_DEBOUNCE_EN`.
- Defined: debouncer as above. `DEBOUNCE_CYCLES` applies.
- Undefined:
  - counters are removed and `stable` <= `sync2` every clock;
  - `stable` changes at n+3 and `edge_capture` at n+4;
  - `DEBOUNCE_CYCLES` is ignored;
  - register map and `irq` behaviour are unchanged.

## Test plan
- Reset behaviour: `WIDTH`=4, `IDLE_LEVEL`=1, inputs held 4'hF through reset.
  - After release: DATA reads 0xF, EDGECAP reads 0, `irq`=0.
  - No capture bit set within 100 clocks.
- Glitch rejection: `DEBOUNCE_CYCLES`=8, `EDGE_MODE`=1, macro defined.
  - Pulse bit0 low for 7 clocks: DATA stays 0xF, EDGECAP stays 0.
  - Hold bit0 low for 8 clocks: DATA=0xE at n+10, EDGECAP=0x1 at n+11.
- Interrupt masking, with EDGECAP=0x1 already set:
  - IRQMASK=0 gives `irq`=0.
  - Write IRQMASK=0x1: `irq`=1 the next cycle.
  - Write EDGECAP 0x1: EDGECAP=0 and `irq`=0 one cycle later.
- Per-bit clear with a set/clear collision:
  - EDGECAP=0x3; write 0x2 leaves 0x1.
  - A bit1 edge landing on the same clock as a write-1-to-clear of bit1 leaves bit1 set.
- Any-edge mode, without the macro: `EDGE_MODE`=2, toggle bit3 1→0→1 with a 5-clock gap.
  - EDGECAP bit3 sets at n+4 after each toggle.
  - RAW and DATA track the input with latencies 2 and 3.
- Reset mid-operation:
  - Assert `reset_n` while a count is at 5 of 8.
  - After release all counters restart. The input must then be held 8 further clocks before DATA changes.

Source files
------------

// File: rtl/pio_in_debounced.sv
// pio_in_debounced: Avalon-MM input port for push-buttons and slide switches.
// Each channel has a two-flop synchroniser, an optional debouncer, and an edge detector.
// The port also has a per-bit interrupt mask and a write-1-to-clear edge-capture register.
// Define PIO_IN_DEBOUNCE_EN to build the per-channel debounce counters.
// Without it, the synchronised input feeds `stable` directly.

// Input path for one channel: synchroniser, debouncer (optional), edge detector.
module pio_in_chan #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_MODE       = 0,
    parameter logic IDLE            = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic sync,
    output logic stable,
    output logic edge_hit
);
    logic sync1;
    logic stable_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE;
            sync  <= IDLE;
        end else begin
            sync1 <= raw;
            sync  <= sync1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Accept a new level only after it has differed from `stable` for DEBOUNCE_CYCLES clocks.
    // Any return to the old level restarts the count from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= IDLE;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            stable <= sync;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    // No debouncing: `stable` follows the synchroniser one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable <= IDLE;
        else          stable <= sync;
    end
`endif

    // Delayed copy of `stable` for edge detection.
    // Resetting it to IDLE keeps reset from producing a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_d <= IDLE;
        else          stable_d <= stable;
    end

    if (EDGE_MODE == 0) begin : g_rise
        assign edge_hit = stable & ~stable_d;
    end else if (EDGE_MODE == 1) begin : g_fall
        assign edge_hit = ~stable & stable_d;
    end else begin : g_any
        assign edge_hit = stable ^ stable_d;
    end
endmodule

// Top level: one channel per input pin, plus the register file and the interrupt.
module pio_in_debounced #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_wd;

    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1 || EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_cfg
        $error("pio_in_debounced: illegal parameter value");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_in_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_MODE       (EDGE_MODE),
            .IDLE            (1'(IDLE_LEVEL))
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw      (in_port[i]),
            .sync     (sync2[i]),
            .stable   (stable[i]),
            .edge_hit (edge_hit[i])
        );
    end

    assign wr        = chipselect && !write_n;
    assign cap_clr   = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wd = ^writedata;

    // Interrupt mask register (address 2).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   irq_mask <= '0;
        else if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end

    // Edge capture: a new edge wins over a same-clock write-1-to-clear, so no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_capture <= '0;
        else          edge_capture <= (edge_capture & ~cap_clr) | edge_hit;
    end

    // Read mux. Unused upper bits are zero-extended.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(stable);
            2'd1:    rd_mux = 32'(sync2);
            2'd2:    rd_mux = 32'(irq_mask);
            default: rd_mux = 32'(edge_capture);
        endcase
    end

    // Read data is registered every clock, whether or not the slave is selected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_pio_in_debounced.sv
// Scoreboard bench for pio_in_debounced.
// Stimulus tasks push expected values into queues.
// Monitors pop them and compare when a read response or an irq sample point occurs.
module tb_pio_in_debounced;
    localparam int DC = 8;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int EM  = 1;
    localparam int LAT = DC + 2;
`else
    localparam int EM  = 2;
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t rd_q[$];
    chk_t irq_q[$];
    bit   rd_stb  = 1'b0;
    bit   rd_d    = 1'b0;
    bit   irq_stb = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    pio_in_debounced #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DC),
        .EDGE_MODE       (EM),
        .IDLE_LEVEL      (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // A read issued in one cycle returns readdata after the next edge.
    always @(posedge clk) rd_d <= rd_stb;

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clk) begin
        chk_t c;
        if (rd_d) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_queue_empty: read response with no expectation, got %0h", readdata);
            end else begin
                c = rd_q.pop_front();
                if (readdata !== c.exp) begin
                    errors++;
                    $display("FAIL %s: readdata got %0h expected %0h", c.name, readdata, c.exp);
                end
            end
        end
        if (irq_stb) begin
            checks++;
            if (irq_q.size() == 0) begin
                errors++;
                $display("FAIL irq_queue_empty: irq sample with no expectation, got %0b", irq);
            end else begin
                c = irq_q.pop_front();
                if ({31'b0, irq} !== c.exp) begin
                    errors++;
                    $display("FAIL %s: irq got %0b expected %0b", c.name, irq, c.exp[0]);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        rd_q.push_back('{nm, e});
        address = a;
        rd_stb  = 1'b1;
        tick();
        rd_stb  = 1'b0;
        address = 2'd0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
    endtask

    task automatic chk_irq(input logic e, input string nm);
        irq_q.push_back('{nm, {31'b0, e}});
        irq_stb = 1'b1;
        @(negedge clk);
        #1;
        irq_stb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Reset behaviour
        tick(3);
        chk_irq(1'b0, "irq_in_reset");
        rd(2'd0, 32'h0, "readdata_in_reset");
        reset_n = 1'b1;
        rd(2'd0, 32'hF, "reset_data");
        rd(2'd1, 32'hF, "reset_raw");
        rd(2'd2, 32'h0, "reset_irqmask");
        rd(2'd3, 32'h0, "reset_edgecap");
        chk_irq(1'b0, "reset_irq");
        for (int i = 0; i < 10; i++) begin
            tick(9);
            rd(2'd3, 32'h0, "no_spurious_edge");
        end

`ifdef PIO_IN_DEBOUNCE_EN
        // A 7-clock glitch must never reach `stable`.
        in_port = 4'hE;
        tick(7);
        in_port = 4'hF;
        tick(LAT + 4);
        rd(2'd0, 32'hF, "glitch_data");
        rd(2'd3, 32'h0, "glitch_edgecap");
`endif

        // Hold bit0 low: DATA changes at LAT, capture one clock later.
        in_port = 4'hE;
        tick(LAT - 1);
        rd(2'd0, 32'hF, "hold_data_before");
        rd(2'd0, 32'hE, "hold_data_after");
        rd(2'd3, 32'h1, "hold_edgecap");
        in_port = 4'hF;
        tick(LAT + 2);
        rd(2'd0, 32'hF, "restore_data");
        rd(2'd3, 32'h1, "restore_edgecap");

        // Interrupt masking
        chk_irq(1'b0, "irq_masked_off");
        wr(2'd2, 32'h1);
        chk_irq(1'b1, "irq_mask_on");
        rd(2'd2, 32'h1, "irqmask_read");
        wr(2'd3, 32'h1);
        chk_irq(1'b0, "irq_after_clear");
        rd(2'd3, 32'h0, "edgecap_after_clear");
        wr(2'd0, 32'h0);
        wr(2'd1, 32'h0);
        rd(2'd0, 32'hF, "data_write_ignored");

        // Per-bit write-1-to-clear
        in_port = 4'hC;
        tick(LAT + 1);
        rd(2'd3, 32'h3, "edgecap_two_bits");
        chk_irq(1'b1, "irq_two_bits");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h1, "perbit_clear");
        chk_irq(1'b1, "irq_bit0_still");
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, "perbit_clear_bit0");
        chk_irq(1'b0, "irq_all_clear");
        in_port = 4'hF;
        tick(LAT + 1);
        rd(2'd3, (EM == 2) ? 32'h3 : 32'h0, "rise_edgecap");
        wr(2'd3, 32'hF);
        rd(2'd3, 32'h0, "clear_all");

        // A set and a clear of bit1 in the same clock: the set wins.
        in_port = 4'hD;
        tick(LAT - 1);
        rd(2'd3, 32'h0, "pre_collision");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h2, "collision_set_wins");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h0, "post_collision_clear");
        in_port = 4'hF;
        tick(LAT + 1);
        wr(2'd3, 32'hF);
        rd(2'd3, 32'h0, "clear_all_2");

        // Toggle bit3: check RAW latency, capture timing, then DATA latency on the way back.
        in_port = 4'h7;
        tick(1);
        rd(2'd1, 32'hF, "raw_before");
        rd(2'd1, 32'h7, "raw_after");
        tick(LAT - 3);
        rd(2'd3, 32'h0, "bit3_cap_before");
        rd(2'd3, 32'h8, "bit3_cap_fall");
        chk_irq(1'b0, "irq_bit3_unmasked");
        wr(2'd3, 32'h8);
        rd(2'd3, 32'h0, "bit3_cleared");
        wr(2'd2, 32'h9);
        in_port = 4'hF;
        tick(LAT - 1);
        rd(2'd0, 32'h7, "bit3_data_before");
        rd(2'd0, 32'hF, "bit3_data_after");
        rd(2'd3, (EM == 2) ? 32'h8 : 32'h0, "bit3_cap_rise");
        chk_irq((EM == 2), "irq_bit3_rise");
        wr(2'd3, 32'hF);
        chk_irq(1'b0, "irq_final_clear");

        // Reset mid-count: the partial count is discarded.
        in_port = 4'hE;
        tick(7);
        reset_n = 1'b0;
        chk_irq(1'b0, "irq_mid_reset");
        rd(2'd0, 32'h0, "readdata_mid_reset");
        reset_n = 1'b1;
        tick(LAT - 1);
        rd(2'd0, 32'hF, "post_reset_data_before");
        rd(2'd0, 32'hE, "post_reset_data_after");
        rd(2'd3, 32'h1, "post_reset_edgecap");
        rd(2'd2, 32'h0, "post_reset_irqmask");
        chk_irq(1'b0, "post_reset_irq");

        tick(2);
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending rd %0d irq %0d expected 0 0", rd_q.size(), irq_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
